seg_scan_display: RTL



---
 rtl/disp_pkg.sv | 31 +++
 rtl/seg_hex_decode.sv | 13 +
 rtl/seg_scan_display.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed seven-segment display: blank pattern,
// active-low hex segment codes {a,b,c,d,e,f,g}, and the digit-index width helper.
package disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n is the active-low code for hex digit n.
    localparam logic [15:0][6:0] SEG_CODE = {
        7'b011_1000,  // F
        7'b011_0000,  // E
        7'b100_0010,  // d
        7'b011_0001,  // C
        7'b110_0000,  // b
        7'b000_1000,  // A
        7'b000_0100,  // 9
        7'b000_0000,  // 8
        7'b000_1111,  // 7
        7'b010_0000,  // 6
        7'b010_0100,  // 5
        7'b100_1100,  // 4
        7'b000_0110,  // 3
        7'b001_0010,  // 2
        7'b100_1111,  // 1
        7'b000_0001   // 0
    };

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment code.
module seg_hex_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_CODE[nibble];
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffering,
// per-digit decimal points, leading-zero blanking and PWM brightness.
// Optional build macro SEG_SCAN_GHOST_BLANK_EN blanks anodes for the first two
// cycles of every digit dwell.
module seg_scan_display #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV_W = 18,
    parameter int DUTY_W     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    input  logic [DUTY_W-1:0]       brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   sel,
    output logic                    frame_done
);
    import disp_pkg::*;

    localparam int IDX_W = idx_width(NUM_DIGITS);

    logic [SCAN_DIV_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic                    blz_q, blz_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;

    logic                    cnt_wrap;
    logic                    frame_wrap;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              cur_code;
    logic [DUTY_W-1:0]       phase;
    logic                    sel_on;

    assign cnt_wrap   = &cnt_q;
    assign frame_wrap = cnt_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign phase      = cnt_q[SCAN_DIV_W-1 -: DUTY_W];

    // Scan position; the index wraps explicitly so non-power-of-2 counts have no phantom digits.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Double buffer: a load coincident with the frame boundary commits the old pending data.
    always_comb begin
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        blz_d      = blz_q;
        if (frame_wrap && pend_vld_q) begin
            act_val_d  = pend_val_q;
            act_dp_d   = pend_dp_q;
            blz_d      = blank_lz;
            pend_vld_d = 1'b0;
        end
        if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_mask;
            pend_vld_d = 1'b1;
        end
    end

    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (act_val_q[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_run && (i != 0) && blz_q;
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = act_val_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = lz_blank[i];
            end
        end
    end

    seg_hex_decode u_dec (
        .nibble (cur_nib),
        .seg    (cur_code)
    );

    always_comb begin
`ifdef SEG_SCAN_GHOST_BLANK_EN
        sel_on = (phase <= brightness) && (cnt_q[SCAN_DIV_W-1:1] != '0);
`else
        sel_on = (phase <= brightness);
`endif
        seg_d = cur_blank ? SEG_BLANK : cur_code;
        dp_d  = ~cur_dp;
        sel_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_d[i] = !(sel_on && (idx_q == IDX_W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            blz_q      <= 1'b0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            sel_q      <= '1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            blz_q      <= blz_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            sel_q      <= sel_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign sel        = sel_q;
    assign frame_done = frame_wrap;

endmodule
